// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, RV32I opcodes and the decoded-instruction record.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {
        SEL_A_RS1,
        SEL_A_PC,
        SEL_A_ZERO
    } sel_a_e;

    typedef enum logic [0:0] {
        SEL_B_RS2,
        SEL_B_IMM
    } sel_b_e;

    typedef struct packed {
        alu_op_e     alu_op;
        sel_a_e      sel_a;
        sel_b_e      sel_b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } decode_t;

    // alt selects SUB/SRA, i.e. instr[30] on the funct7 = 0x20 encodings
    function automatic alu_op_e funct3_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU operation, operand selects and writeback info.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output decode_t     dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic        legal;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u  = {instr_i[31:12], 12'b0};

    always_comb begin
        dec_o         = '0;
        dec_o.alu_op  = ALU_ADD;
        dec_o.sel_a   = SEL_A_ZERO;
        dec_o.sel_b   = SEL_B_IMM;
        dec_o.rd      = instr_i[11:7];
        legal         = 1'b1;

        unique case (opcode)
            OPC_OP: begin
                dec_o.sel_a = SEL_A_RS1;
                dec_o.sel_b = SEL_B_RS2;
                dec_o.rd_we = 1'b1;
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_o.alu_op = funct3_op(funct3, funct7[5]);
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_o.sel_a = SEL_A_RS1;
                dec_o.rd_we = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_o.imm = {27'b0, instr_i[24:20]};
                    if (funct7 == F7_BASE || (funct7 == F7_ALT && funct3 == 3'b101)) begin
                        dec_o.alu_op = funct3_op(funct3, funct7[5]);
                    end else begin
                        legal = 1'b0;
                    end
                end else begin
                    dec_o.imm    = imm_i;
                    dec_o.alu_op = funct3_op(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                dec_o.imm   = imm_u;
                dec_o.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.sel_a = SEL_A_PC;
                dec_o.imm   = imm_u;
                dec_o.rd_we = 1'b1;
            end
            OPC_LOAD: begin
                dec_o.sel_a = SEL_A_RS1;
                dec_o.imm   = imm_i;
                dec_o.rd_we = 1'b1;
            end
            OPC_STORE: begin
                dec_o.sel_a = SEL_A_RS1;
                dec_o.imm   = imm_s;
            end
            OPC_JAL, OPC_JALR: begin
                dec_o.sel_a = SEL_A_PC;
                dec_o.imm   = 32'd4;
                dec_o.rd_we = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec_o.alu_op  = ALU_ADD;
            dec_o.sel_a   = SEL_A_ZERO;
            dec_o.sel_b   = SEL_B_IMM;
            dec_o.imm     = '0;
            dec_o.rd_we   = 1'b0;
            dec_o.illegal = 1'b1;
        end
        if (dec_o.rd == 5'd0) begin
            dec_o.rd_we = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: decodes an instruction, muxes ALU operands and holds them in a one-entry valid/ready register.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [OP_WIDTH-1:0]   alu_op_o,
    output logic [DATA_WIDTH-1:0] operand_a_o,
    output logic [DATA_WIDTH-1:0] operand_b_o,
    output logic [4:0]            rd_addr_o,
    output logic                  rd_we_o,
    output logic                  illegal_o
);

    decode_t dec;

    logic                  load;
    logic                  valid_q, valid_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] operand_a_q, operand_a_d;
    logic [DATA_WIDTH-1:0] operand_b_q, operand_b_d;
    logic [4:0]            rd_addr_q, rd_addr_d;
    logic                  rd_we_q, rd_we_d;
    logic                  illegal_q, illegal_d;

    alu_op_decode u_decode (
        .instr_i (instr_i),
        .dec_o   (dec)
    );

    // Accept whenever the held entry leaves this cycle, so full throughput has no bubble
    assign ready_o = !valid_q || ready_i;
    assign load    = valid_i && ready_o && !flush_i;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        alu_op_d    = alu_op_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        rd_addr_d   = rd_addr_q;
        rd_we_d     = rd_we_q;
        illegal_d   = illegal_q;
        if (load) begin
            alu_op_d  = OP_WIDTH'(dec.alu_op);
            rd_addr_d = dec.rd;
            rd_we_d   = dec.rd_we;
            illegal_d = dec.illegal;
            case (dec.sel_a)
                SEL_A_RS1: operand_a_d = rs1_data_i;
                SEL_A_PC:  operand_a_d = pc_i;
                default:   operand_a_d = '0;
            endcase
            case (dec.sel_b)
                SEL_B_RS2: operand_b_d = rs2_data_i;
                default:   operand_b_d = DATA_WIDTH'(dec.imm);
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            alu_op_q    <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            rd_addr_q   <= '0;
            rd_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alu_op_q    <= alu_op_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            rd_addr_q   <= rd_addr_d;
            rd_we_q     <= rd_we_d;
            illegal_q   <= illegal_d;
        end
    end

    assign valid_o     = valid_q;
    assign alu_op_o    = alu_op_q;
    assign operand_a_o = operand_a_q;
    assign operand_b_o = operand_b_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_we_o     = rd_we_q;
    assign illegal_o   = illegal_q;

endmodule
